// File: rtl/xor_acc_pkg.sv
// ---------------------------------------------------------------------------
// xor_acc_pkg
// Shared definitions for the XOR stream accumulator slice.
//   state_t     : output-register state (ST_EMPTY / ST_FULL)
//   DEF_WIDTH   : default data word width
//   DEF_CNT_W   : default word-counter width (counter built only with
//                 XOR_ACC_COUNT_EN)
//   satInc()    : saturating increment on a 32-bit container
// ---------------------------------------------------------------------------
package xor_acc_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Callers zero-extend a narrower counter into the 32-bit container and pass
  // the all-ones value of their own width as the ceiling.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input logic [31:0] maxVal);
    return (value >= maxVal) ? maxVal : value + 32'd1;
  endfunction

endpackage

// File: rtl/xor_fold_reg.sv
// ---------------------------------------------------------------------------
// xor_fold_reg
// WIDTH-bit XOR accumulate register with load-clear and async reset.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (accumulator -> 0)
//   i_en     : update enable (one accepted word)
//   i_clear  : with i_en, clear the accumulator instead of folding
//   i_data   : word to fold in
//   o_next   : acc ^ i_data, the fold including the current word
// ---------------------------------------------------------------------------
module xor_fold_reg
  import xor_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_acc;

  assign o_next = r_acc ^ i_data;

  // On the final word of a packet the result is taken from o_next by the
  // parent, so the accumulator starts the following packet from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_acc <= '0;
      end else begin
        r_acc <= o_next;
      end
    end
  end

endmodule

// File: rtl/xor_stream_accumulator.sv
// ---------------------------------------------------------------------------
// xor_stream_accumulator
// XOR-folds a valid/ready stream of WIDTH-bit words over each packet
// (delimited by in_last) and emits one result per packet: the XOR of all
// words plus its parity, held in a single-entry output register.
// Optional feature macro: XOR_ACC_COUNT_EN adds CNT_W and out_count, a
// saturating count of words in the packet.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   in_valid    : input word present
//   in_ready    : word accepted this cycle (!out_valid || out_ready)
//   in_data     : input word
//   in_last     : final word of its packet
//   out_valid   : packet result held
//   out_ready   : consumer takes the result
//   out_data    : XOR of all words of the packet
//   out_parity  : reduction XOR of out_data
//   out_count   : words in packet, saturating (XOR_ACC_COUNT_EN only)
// ---------------------------------------------------------------------------
module xor_stream_accumulator
  import xor_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef XOR_ACC_COUNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity
`ifdef XOR_ACC_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_outData;
  logic             r_outParity;

  logic             w_accept;
  logic             w_acceptLast;
  logic             w_produce;
  logic [WIDTH-1:0] w_foldNext;

  // The output register drains and refills in the same edge, so input is
  // only blocked while a result is held and the consumer is not taking it.
  assign in_ready     = (r_state == ST_EMPTY) || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_acceptLast = w_accept && in_last;
  assign w_produce    = out_valid && out_ready;

  assign out_valid  = (r_state == ST_FULL);
  assign out_data   = r_outData;
  assign out_parity = r_outParity;

  xor_fold_reg #(
    .WIDTH (WIDTH)
  ) u_fold (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_accept),
    .i_clear (in_last),
    .i_data  (in_data),
    .o_next  (w_foldNext)
  );

`ifdef XOR_ACC_COUNT_EN
  // Counter ceiling kept in a 32-bit container, so CNT_W is limited to 32.
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outCount;
  logic [CNT_W-1:0] w_countNext;

  assign w_countNext = CNT_W'(satInc(32'(r_count), CNT_MAX));
  assign out_count   = r_outCount;

  // Counts words of the packet in progress; the last word's increment goes
  // straight into the output register and the counter restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (in_last) begin
        r_count <= '0;
      end else begin
        r_count <= w_countNext;
      end
    end
  end
`endif

  // Output register FSM. A new result always loads on accept-with-last,
  // even while FULL, because that accept can only happen when the held
  // result is being produced in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_outData   <= '0;
      r_outParity <= 1'b0;
`ifdef XOR_ACC_COUNT_EN
      r_outCount  <= '0;
`endif
    end else begin
      if (w_acceptLast) begin
        r_outData   <= w_foldNext;
        r_outParity <= ^w_foldNext;
`ifdef XOR_ACC_COUNT_EN
        r_outCount  <= w_countNext;
`endif
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_acceptLast) begin
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_produce && !w_acceptLast) begin
            r_state <= ST_EMPTY;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_accumulator
// Directed bench for xor_stream_accumulator (WIDTH=8). With XOR_ACC_COUNT_EN
// the DUT is built with CNT_W=2 so the saturation case is reachable.
// ---------------------------------------------------------------------------
module tb_xor_stream_accumulator;

  logic       clock;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       inLast;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       outParity;
`ifdef XOR_ACC_COUNT_EN
  logic [1:0] outCount;
`endif

  int testCount = 0;
  int failCount = 0;

  // 10 time-unit clock; rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef XOR_ACC_COUNT_EN
  xor_stream_accumulator #(
    .WIDTH (8),
    .CNT_W (2)
  ) dut (
    .clk        (clock),
    .rst        (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .in_last    (inLast),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_parity (outParity),
    .out_count  (outCount)
  );
`else
  xor_stream_accumulator #(
    .WIDTH (8)
  ) dut (
    .clk        (clock),
    .rst        (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .in_last    (inLast),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_parity (outParity)
  );
`endif

  // Drives all stimulus inputs at once, away from the clock edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic last, input logic rdy);
    inValid  = valid;
    inData   = data;
    inLast   = last;
    outReady = rdy;
  endtask

  // Advances one rising edge and settles 1 unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed,
                          input logic expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0b expected %0b", tag, observed, expected);
    end
  endtask

  // Word count check; no-op when the counter is not built.
  task automatic checkCount(input string tag, input logic [1:0] expected);
`ifdef XOR_ACC_COUNT_EN
    testCount++;
    assert (outCount === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, outCount, expected);
    end
`else
    if (tag.len() == 0 && expected == 2'd0) begin
      $display("[TB] note: empty count tag");
    end
`endif
  endtask

  // Checks a freshly loaded result: valid, data, parity, count.
  task automatic checkResult(input string tag, input logic [7:0] expData,
                             input logic expParity, input logic [1:0] expCount);
    checkBit({tag, "_valid"}, outValid, 1'b1);
    checkOutput({tag, "_data"}, outData, expData);
    checkBit({tag, "_parity"}, outParity, expParity);
    checkCount({tag, "_count"}, expCount);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    checkBit("rst_valid", outValid, 1'b0);
    checkOutput("rst_data", outData, 8'h00);
    checkBit("rst_parity", outParity, 1'b0);
    checkCount("rst_count", 2'd0);
    reset = 1'b0;
    #1;
    checkBit("rst_inready", inReady, 1'b1);

    // Three-word packet: 0F ^ F0 ^ 3C = C3, parity 0
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b1);
    tick();
    checkBit("p3_w1_valid", outValid, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1);
    tick();
    checkBit("p3_w2_valid", outValid, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    checkResult("p3", 8'hC3, 1'b0, 2'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkBit("p3_onecycle", outValid, 1'b0);

    // Back-to-back single-word packets
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
    #1;
    checkBit("s1_inready", inReady, 1'b1);
    tick();
    checkResult("s1", 8'h01, 1'b1, 2'd1);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
    #1;
    checkBit("s2_inready", inReady, 1'b1);
    tick();
    checkResult("s2", 8'h03, 1'b0, 2'd1);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1);
    #1;
    checkBit("s3_inready", inReady, 1'b1);
    tick();
    checkResult("s3", 8'h07, 1'b1, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkBit("s_drained", outValid, 1'b0);

    // Backpressure: AA ^ 55 = FF held while out_ready is low
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    tick();
    checkResult("bp", 8'hFF, 1'b0, 2'd2);
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkBit("bp_stall_inready", inReady, 1'b0);
      checkBit("bp_stall_valid", outValid, 1'b1);
      checkOutput("bp_stall_data", outData, 8'hFF);
      checkBit("bp_stall_parity", outParity, 1'b0);
      tick();
    end
    outReady = 1'b1;
    #1;
    checkBit("bp_release_inready", inReady, 1'b1);
    tick();
    checkResult("bp_next", 8'h11, 1'b0, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkBit("bp_drained", outValid, 1'b0);

    // Idle gaps inside a packet: 12 ^ 34 = 26, parity 1
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
    tick();
    checkBit("gap_idle1_valid", outValid, 1'b0);
    tick();
    checkBit("gap_idle2_valid", outValid, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b1);
    tick();
    checkResult("gap", 8'h26, 1'b1, 2'd2);

    // Six words of 01: XOR 00, count saturates at 3 with CNT_W=2
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'h01, (i == 5), 1'b1);
      tick();
    end
    checkResult("sat", 8'h00, 1'b0, 2'd3);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b1);
    tick();
    checkResult("sat_next", 8'h80, 1'b1, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();

    // Reset while a result is held: 5A ^ 0F = 55 held, then async reset
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h0F, 1'b1, 1'b0);
    tick();
    checkResult("hold", 8'h55, 1'b0, 2'd2);
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkBit("arst_valid", outValid, 1'b0);
    checkOutput("arst_data", outData, 8'h00);
    checkBit("arst_parity", outParity, 1'b0);
    checkCount("arst_count", 2'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkBit("arst_inready", inReady, 1'b1);

    // Reset mid-packet discards the partial fold
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    applyStimulus(1'b1, 8'h38, 1'b1, 1'b1);
    tick();
    checkResult("partial", 8'h38, 1'b1, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkBit("end_drained", outValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
